// File: rtl/data_fetch_unit_pkg.sv
// Shared types and helpers for the load-side data fetch stage.
// Holds the fetch modes, FSM states, lane count and the words-per-mode lookup.
package fetch_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SINGLE = 2'd0,
    PAIR   = 2'd1,
    QUAD   = 2'd2
  } fetch_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [2:0] words_for_mode(input fetch_mode_e mode);
    logic [2:0] n;
    case (mode)
      SINGLE:  n = 3'd1;
      PAIR:    n = 3'd2;
      QUAD:    n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/data_fetch_unit_if.sv
// Request/memory/lane bundle for the data fetch unit.
// The slave side is the fetch unit; the master side is the requester plus memory.
interface data_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 8
);

  logic                                ADDR_START;
  logic                                ADDR_RST;
  logic [3:0]                          ADDRESS;
  logic [1:0]                          PE_SEL;
  logic                                PE_SEL_2x2;
  logic                                PE_SEL_4;
  logic                                FETCH_DONE;
  logic                                BUSY;
  logic                                MEM_RDEN;
  logic [MEM_AW-1:0]                   MEM_ADDR;
  logic [DATA_W-1:0]                   MEM_RDATA;
  logic [NUM_LANES-1:0][DATA_W-1:0]    DATAIN;

  modport master (
    output ADDR_START, ADDR_RST, ADDRESS, PE_SEL, PE_SEL_2x2, PE_SEL_4, MEM_RDATA,
    input  FETCH_DONE, BUSY, MEM_RDEN, MEM_ADDR, DATAIN
  );

  modport slave (
    input  ADDR_START, ADDR_RST, ADDRESS, PE_SEL, PE_SEL_2x2, PE_SEL_4, MEM_RDATA,
    output FETCH_DONE, BUSY, MEM_RDEN, MEM_ADDR, DATAIN
  );

endinterface

// File: rtl/data_fetch_unit_lane_regs.sv
// Four per-PE lane registers; one lane is written per cycle when enabled,
// the others hold their value.
module fetch_lane_regs
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             wr_en_i,
  input  logic [1:0]                       lane_i,
  input  logic [DATA_W-1:0]                wdata_i,
  output logic [NUM_LANES-1:0][DATA_W-1:0] lanes_o
);

  logic [NUM_LANES-1:0][DATA_W-1:0] lanes_q;

  // Lane storage: cleared by reset, single-lane write otherwise
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lanes_q <= '0;
    end else if (wr_en_i) begin
      lanes_q[lane_i] <= wdata_i;
    end else begin
      lanes_q <= lanes_q;
    end
  end

  assign lanes_o = lanes_q;

endmodule

// File: rtl/data_fetch_unit.sv
// Fetches 1, 2 or 4 consecutive words from a synchronous-read memory into the
// PE lane registers, advancing a running word pointer after each completed fetch.
module data_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 8
) (
  input logic             CLK,
  input logic             RST,
  data_fetch_unit_if.slave bus
);

  fetch_state_e      state_q;
  fetch_mode_e       mode_q;
  logic [1:0]        pe_sel_q;
  logic [1:0]        k_q;
  logic [1:0]        last_q;
  logic [MEM_AW-1:0] ptr_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic              mem_rden_q;
  logic              busy_q;
  logic              done_q;

  fetch_mode_e       mode_s;
  logic [2:0]        n_s;
  logic [1:0]        last_s;
  logic [MEM_AW-1:0] row_addr_s;
  logic              cap_en_s;
  logic [1:0]        cap_k_s;
  logic [1:0]        cap_idx_s;

  assign row_addr_s = MEM_AW'({bus.ADDRESS, 2'b00});

  // Request decode: quad overrides pair, pair overrides single
  always_comb begin
    mode_s = SINGLE;
    if (bus.PE_SEL_4) begin
      mode_s = QUAD;
    end else if (bus.PE_SEL_2x2) begin
      mode_s = PAIR;
    end else begin
      mode_s = SINGLE;
    end
    n_s    = words_for_mode(mode_s);
    last_s = 2'(n_s - 3'd1);
  end

  // Capture select: data on MEM_RDATA belongs to the word requested one cycle earlier.
  // A word already on the bus is still captured on the edge that sees ADDR_RST.
  always_comb begin
    cap_en_s  = 1'b0;
    cap_k_s   = 2'd0;
    cap_idx_s = 2'd0;
    case (state_q)
      READ: begin
        if (k_q != 2'd0) begin
          cap_en_s = 1'b1;
          cap_k_s  = k_q - 2'd1;
        end else begin
          cap_en_s = 1'b0;
        end
      end
      DRAIN: begin
        cap_en_s = 1'b1;
        cap_k_s  = k_q;
      end
      default: cap_en_s = 1'b0;
    endcase
    case (mode_q)
      QUAD:    cap_idx_s = cap_k_s;
      PAIR:    cap_idx_s = {pe_sel_q[1], cap_k_s[0]};
      default: cap_idx_s = pe_sel_q;
    endcase
  end

  // Fetch sequencer with registered memory/status outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      mode_q     <= SINGLE;
      pe_sel_q   <= 2'd0;
      k_q        <= 2'd0;
      last_q     <= 2'd0;
      ptr_q      <= '0;
      mem_addr_q <= '0;
      mem_rden_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.ADDR_RST) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      ptr_q      <= '0;
      mem_rden_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.ADDR_START) begin
            state_q    <= READ;
            mode_q     <= mode_s;
            pe_sel_q   <= bus.PE_SEL;
            last_q     <= last_s;
            k_q        <= 2'd0;
            mem_addr_q <= row_addr_s + ptr_q;
            mem_rden_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        READ: begin
          if (k_q == last_q) begin
            state_q    <= DRAIN;
            mem_rden_q <= 1'b0;
          end else begin
            k_q        <= k_q + 2'd1;
            mem_addr_q <= mem_addr_q + MEM_AW'(1);
          end
        end
        DRAIN: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_q + MEM_AW'(words_for_mode(mode_q));
        end
        default: begin
          state_q    <= IDLE;
          mem_rden_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  fetch_lane_regs #(.DATA_W(DATA_W)) u_lanes (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en_i (cap_en_s),
    .lane_i  (cap_idx_s),
    .wdata_i (bus.MEM_RDATA),
    .lanes_o (bus.DATAIN)
  );

  assign bus.FETCH_DONE = done_q;
  assign bus.BUSY       = busy_q;
  assign bus.MEM_RDEN   = mem_rden_q;
  assign bus.MEM_ADDR   = mem_addr_q;

endmodule
